output_queue_bypass_arbiter_mc: RTL
===================================

Name: output_queue_bypass_arbiter_mc

Overview:
- Multi-calendar successor to the root-PIFO bypass checker.
- Compares an incoming root PIFO descriptor against NUM_CAL calendar-queue tops and decides whether the packet may bypass the output queue.
- Adds a timed GPFC pause window and an anti-starvation consecutive-bypass limit.
- Sits between the root PIFO lookup and the output-queue enqueue logic, using a 2-stage valid/ready pipeline.

Parameters:
- PIFO_RANK_WIDTH, 19, rank field width.
- PIFO_ROOT_WIDTH, 32, descriptor width.
- ROOT_RANK_START_POS, 12, rank LSB in descriptor.
- ROOT_RANK_END_POS, 30, rank MSB in descriptor.
- ROOT_PIFO_INFO_VALID_POS, 31, descriptor valid bit.
- NUM_CAL, 4, number of calendar tops compared (>=1).
- CAL_IDX_WIDTH, 2, clog2(NUM_CAL), minimum 1.
- MAX_BYPASS_RUN, 8, maximum consecutive bypasses while a calendar top is valid; 0 disables the limit.
- PAUSE_TIMER_WIDTH, 16, width of the GPFC pause quanta counter.
- STAT_WIDTH, 32, width of the statistics counters.

Ports:
- clk  in  1  clock; only clock in the block.
- rst  in  1  synchronous reset, active-high.
- s_axis_valid  in  1  input descriptor valid.
- s_axis_ready  out  1  input accepted when valid&ready.
- s_axis_pifo_info  in  PIFO_ROOT_WIDTH  root PIFO descriptor.
- s_axis_cal_tops  in  NUM_CAL*PIFO_ROOT_WIDTH  calendar tops; entry i at bits [i*W +: W].
- s_axis_gpfc_valid  in  1  pause command strobe.
- s_axis_gpfc_pause_rank  in  PIFO_RANK_WIDTH  ranks >= this value are paused.
- s_axis_gpfc_pause_quanta  in  PAUSE_TIMER_WIDTH  pause duration in cycles; 0 means resume.
- m_axis_valid  out  1  decision valid.
- m_axis_ready  in  1  downstream ready.
- m_axis_pifo_info  out  PIFO_ROOT_WIDTH  descriptor passthrough.
- m_axis_bypass_en  out  1  1 = bypass, 0 = enqueue.
- m_axis_cal_idx  out  CAL_IDX_WIDTH  index of the minimum-rank valid calendar top (0 if none valid).
- pause_active  out  1  pause FSM is in PAUSED.
- stat_bypass_cnt  out  STAT_WIDTH  bypass decisions delivered.
- stat_forced_enq_cnt  out  STAT_WIDTH  bypasses denied by the run limit.

Behaviour:
- Reset: all registers and outputs are 0, pause FSM is IDLE and run_cnt is 0. s_axis_ready is forced to 0 while rst=1.
- Pipeline enable: en = ~m_axis_valid | m_axis_ready, and s_axis_ready = en & ~rst. Both stages advance only when en=1. Latency from acceptance to m_axis_valid is 2 cycles. Output registers hold their values while stalled.
- Stage 1 (registered): descriptor; min_rank, min_idx and any_cal_valid computed by a comparator tree over the valid calendar tops.
  - Ties resolve to the lowest index.
  - Calendar tops and the descriptor are sampled on the acceptance cycle only.
- Pause FSM:
  - IDLE to PAUSED on gpfc_valid with quanta!=0: loads pause_rank and timer=quanta.
  - In PAUSED the timer decrements each cycle and the FSM returns to IDLE in the cycle the timer reaches 0.
  - gpfc_valid in PAUSED with quanta!=0 reloads rank and timer; a reload wins over a simultaneous expiry.
  - gpfc_valid with quanta=0 goes to IDLE the next cycle.
  - The FSM advances every cycle, independent of en. A command takes effect from the following cycle.
- Stage 2 decision, using pause state and run_cnt in the cycle stage 2 loads:
  - raw = desc_valid & (~any_cal_valid | rank < min_rank) & ~(PAUSED & rank >= pause_rank).
  - forced = raw & any_cal_valid & MAX_BYPASS_RUN!=0 & run_cnt==MAX_BYPASS_RUN.
  - bypass_en = raw & ~forced.
- run_cnt updates only on a stage-2 load with s1 valid:
  - increments when bypass_en=1 and any_cal_valid=1;
  - resets to 0 on forced or on an enqueue decision;
  - holds when bypassing with no valid calendar top.
- Statistics: stat_bypass_cnt increments on m_axis_valid&m_axis_ready&bypass_en. stat_forced_enq_cnt increments at the stage-2 load where forced=1. Both saturate at all-ones.
- An invalid descriptor (valid bit 0) always produces bypass_en=0 but is still passed through.
- A reset mid-operation drops in-flight packets and clears the pause state and counters.

Decomposition:
- Shared package: field-position constants, rank/index typedefs, pause FSM state encoding.
- One sub-module: cal_min_rank_tree (parametrised NUM_CAL, combinational argmin with lowest-index tiebreak), instantiated in stage 1.

Test Plan:
- No valid calendar tops, rank 5 accepted at cycle 0 -> m_axis_valid at cycle 2, bypass_en=1, cal_idx=0.
- Calendar ranks {40,10,10,30} all valid, descriptor rank 9 -> bypass=1, cal_idx=1; rank 10 -> bypass=0 (strict less-than).
- gpfc rank 8, quanta 5, then descriptor rank 9 with all tops at 100 arriving while paused -> bypass=0; same descriptor after 5 cycles -> bypass=1; quanta=0 command -> pause_active drops the next cycle.
- MAX_BYPASS_RUN=2, tops valid at 100, five descriptors at rank 1 -> bypass 1,1,0,1,1 and stat_forced_enq_cnt=1.
- Hold m_axis_ready=0 for 4 cycles with traffic -> s_axis_ready=0, outputs stable, no packet lost or duplicated, run_cnt unchanged.
- Assert rst with 2 packets in flight and pause active -> the next cycle has all outputs 0, pause_active=0, counters 0.

Source files
------------

// File: rtl/output_queue_bypass_arbiter_mc_pkg.sv
// Shared constants, typedefs and pause FSM encoding for the multi-calendar
// output-queue bypass arbiter.
package output_queue_bypass_arbiter_mc_pkg;

    localparam int DEF_PIFO_RANK_WIDTH          = 19;
    localparam int DEF_PIFO_ROOT_WIDTH          = 32;
    localparam int DEF_ROOT_RANK_START_POS      = 12;
    localparam int DEF_ROOT_RANK_END_POS        = 30;
    localparam int DEF_ROOT_PIFO_INFO_VALID_POS = 31;
    localparam int DEF_NUM_CAL                  = 4;
    localparam int DEF_CAL_IDX_WIDTH            = 2;
    localparam int DEF_MAX_BYPASS_RUN           = 8;
    localparam int DEF_PAUSE_TIMER_WIDTH        = 16;
    localparam int DEF_STAT_WIDTH               = 32;

    typedef logic [DEF_PIFO_RANK_WIDTH-1:0] rank_t;
    typedef logic [DEF_CAL_IDX_WIDTH-1:0]   cal_idx_t;

    typedef enum logic {
        PAUSE_IDLE   = 1'b0,
        PAUSE_PAUSED = 1'b1
    } pause_state_e;

endpackage

// File: rtl/output_queue_bypass_arbiter_mc_if.sv
// Descriptor-in / decision-out bus of the bypass arbiter, plus the GPFC pause strobe.
interface output_queue_bypass_arbiter_mc_if #(
    parameter int PIFO_ROOT_WIDTH   = 32,
    parameter int PIFO_RANK_WIDTH   = 19,
    parameter int NUM_CAL           = 4,
    parameter int CAL_IDX_WIDTH     = 2,
    parameter int PAUSE_TIMER_WIDTH = 16
);
    // Both s_axis and m_axis transfer on a cycle where valid & ready are high;
    // a source holds valid and data stable until that cycle, and ready may depend on valid.
    logic                               s_axis_valid;
    logic                               s_axis_ready;
    logic [PIFO_ROOT_WIDTH-1:0]         s_axis_pifo_info;
    logic [NUM_CAL*PIFO_ROOT_WIDTH-1:0] s_axis_cal_tops;
    logic                               s_axis_gpfc_valid;
    logic [PIFO_RANK_WIDTH-1:0]         s_axis_gpfc_pause_rank;
    logic [PAUSE_TIMER_WIDTH-1:0]       s_axis_gpfc_pause_quanta;
    logic                               m_axis_valid;
    logic                               m_axis_ready;
    logic [PIFO_ROOT_WIDTH-1:0]         m_axis_pifo_info;
    logic                               m_axis_bypass_en;
    logic [CAL_IDX_WIDTH-1:0]           m_axis_cal_idx;

    modport slave (
        input  s_axis_valid, s_axis_pifo_info, s_axis_cal_tops,
        input  s_axis_gpfc_valid, s_axis_gpfc_pause_rank, s_axis_gpfc_pause_quanta,
        input  m_axis_ready,
        output s_axis_ready, m_axis_valid, m_axis_pifo_info, m_axis_bypass_en, m_axis_cal_idx
    );

    modport master (
        output s_axis_valid, s_axis_pifo_info, s_axis_cal_tops,
        output s_axis_gpfc_valid, s_axis_gpfc_pause_rank, s_axis_gpfc_pause_quanta,
        output m_axis_ready,
        input  s_axis_ready, m_axis_valid, m_axis_pifo_info, m_axis_bypass_en, m_axis_cal_idx
    );
endinterface

// File: rtl/output_queue_bypass_arbiter_mc_cal_min_rank_tree.sv
// Combinational argmin over the valid calendar tops; ties go to the lowest index.
module cal_min_rank_tree #(
    parameter int NUM_CAL         = 4,
    parameter int PIFO_ROOT_WIDTH = 32,
    parameter int PIFO_RANK_WIDTH = 19,
    parameter int CAL_IDX_WIDTH   = 2,
    parameter int RANK_START_POS  = 12,
    parameter int VALID_POS       = 31
) (
    input  logic [NUM_CAL*PIFO_ROOT_WIDTH-1:0] cal_tops,
    output logic [PIFO_RANK_WIDTH-1:0]         min_rank,
    output logic [CAL_IDX_WIDTH-1:0]           min_idx,
    output logic                               any_valid
);
    logic                       top_valid;
    logic [PIFO_RANK_WIDTH-1:0] top_rank;
    logic                       unused_top_bits;

    assign unused_top_bits = ^cal_tops;

    always_comb begin
        min_rank  = '0;
        min_idx   = '0;
        any_valid = 1'b0;
        top_valid = 1'b0;
        top_rank  = '0;
        for (int i = 0; i < NUM_CAL; i++) begin
            top_valid = cal_tops[i*PIFO_ROOT_WIDTH + VALID_POS];
            top_rank  = cal_tops[i*PIFO_ROOT_WIDTH + RANK_START_POS +: PIFO_RANK_WIDTH];
            // Strict less-than keeps the earlier index on a tie.
            if (top_valid && (!any_valid || top_rank < min_rank)) begin
                min_rank  = top_rank;
                min_idx   = CAL_IDX_WIDTH'(i);
                any_valid = 1'b1;
            end
        end
    end
endmodule

// File: rtl/output_queue_bypass_arbiter_mc.sv
// Two-stage bypass decision: stage 1 registers the descriptor and calendar minimum,
// stage 2 applies the GPFC pause window and the consecutive-bypass limit.
module output_queue_bypass_arbiter_mc
    import output_queue_bypass_arbiter_mc_pkg::*;
#(
    parameter int PIFO_RANK_WIDTH          = DEF_PIFO_RANK_WIDTH,
    parameter int PIFO_ROOT_WIDTH          = DEF_PIFO_ROOT_WIDTH,
    parameter int ROOT_RANK_START_POS      = DEF_ROOT_RANK_START_POS,
    parameter int ROOT_RANK_END_POS        = DEF_ROOT_RANK_END_POS,
    parameter int ROOT_PIFO_INFO_VALID_POS = DEF_ROOT_PIFO_INFO_VALID_POS,
    parameter int NUM_CAL                  = DEF_NUM_CAL,
    parameter int CAL_IDX_WIDTH            = DEF_CAL_IDX_WIDTH,
    parameter int MAX_BYPASS_RUN           = DEF_MAX_BYPASS_RUN,
    parameter int PAUSE_TIMER_WIDTH        = DEF_PAUSE_TIMER_WIDTH,
    parameter int STAT_WIDTH               = DEF_STAT_WIDTH,
    localparam int RUN_W = (MAX_BYPASS_RUN < 1) ? 1 : $clog2(MAX_BYPASS_RUN + 1)
) (
    input  logic                                   clk,
    input  logic                                   rst,
    output_queue_bypass_arbiter_mc_if.slave        bus,
    output logic                                   pause_active,
    output logic [STAT_WIDTH-1:0]                  stat_bypass_cnt,
    output logic [STAT_WIDTH-1:0]                  stat_forced_enq_cnt,
    output pause_state_e                           dbg_pause_state,
    output logic [RUN_W-1:0]                       dbg_run_cnt
);
    logic en, accept, load2;

    logic                       tree_any;
    logic [PIFO_RANK_WIDTH-1:0] tree_min_rank;
    logic [CAL_IDX_WIDTH-1:0]   tree_min_idx;

    logic                       s1_valid_q, s1_valid_d;
    logic [PIFO_ROOT_WIDTH-1:0] s1_desc_q, s1_desc_d;
    logic [PIFO_RANK_WIDTH-1:0] s1_min_rank_q, s1_min_rank_d;
    logic [CAL_IDX_WIDTH-1:0]   s1_min_idx_q, s1_min_idx_d;
    logic                       s1_any_q, s1_any_d;

    logic                       m_valid_q, m_valid_d;
    logic [PIFO_ROOT_WIDTH-1:0] m_desc_q, m_desc_d;
    logic                       m_bypass_q, m_bypass_d;
    logic [CAL_IDX_WIDTH-1:0]   m_idx_q, m_idx_d;

    pause_state_e                 pause_state_q, pause_state_d;
    logic [PIFO_RANK_WIDTH-1:0]   pause_rank_q, pause_rank_d;
    logic [PAUSE_TIMER_WIDTH-1:0] timer_q, timer_d;

    logic [RUN_W-1:0]      run_cnt_q, run_cnt_d;
    logic [STAT_WIDTH-1:0] bypass_cnt_q, bypass_cnt_d;
    logic [STAT_WIDTH-1:0] forced_cnt_q, forced_cnt_d;

    logic [PIFO_RANK_WIDTH-1:0] s1_rank;
    logic s1_desc_valid, paused, raw, limit_hit, forced, bypass;

    assign en               = ~m_valid_q | bus.m_axis_ready;
    assign bus.s_axis_ready = en & ~rst;
    assign accept           = bus.s_axis_valid & en & ~rst;
    assign load2            = en & s1_valid_q;

    cal_min_rank_tree #(
        .NUM_CAL        (NUM_CAL),
        .PIFO_ROOT_WIDTH(PIFO_ROOT_WIDTH),
        .PIFO_RANK_WIDTH(PIFO_RANK_WIDTH),
        .CAL_IDX_WIDTH  (CAL_IDX_WIDTH),
        .RANK_START_POS (ROOT_RANK_START_POS),
        .VALID_POS      (ROOT_PIFO_INFO_VALID_POS)
    ) u_tree (
        .cal_tops (bus.s_axis_cal_tops),
        .min_rank (tree_min_rank),
        .min_idx  (tree_min_idx),
        .any_valid(tree_any)
    );

    always_comb begin
        s1_rank       = s1_desc_q[ROOT_RANK_END_POS:ROOT_RANK_START_POS];
        s1_desc_valid = s1_desc_q[ROOT_PIFO_INFO_VALID_POS];
        paused        = (pause_state_q == PAUSE_PAUSED);
        raw           = s1_desc_valid & (~s1_any_q | (s1_rank < s1_min_rank_q))
                        & ~(paused & (s1_rank >= pause_rank_q));
        limit_hit     = (MAX_BYPASS_RUN != 0) && (run_cnt_q == RUN_W'(MAX_BYPASS_RUN));
        forced        = raw & s1_any_q & limit_hit;
        bypass        = raw & ~forced;
    end

    always_comb begin
        s1_valid_d    = s1_valid_q;
        s1_desc_d     = s1_desc_q;
        s1_min_rank_d = s1_min_rank_q;
        s1_min_idx_d  = s1_min_idx_q;
        s1_any_d      = s1_any_q;
        m_valid_d     = m_valid_q;
        m_desc_d      = m_desc_q;
        m_bypass_d    = m_bypass_q;
        m_idx_d       = m_idx_q;
        run_cnt_d     = run_cnt_q;
        bypass_cnt_d  = bypass_cnt_q;
        forced_cnt_d  = forced_cnt_q;
        if (en) begin
            s1_valid_d = accept;
            m_valid_d  = s1_valid_q;
        end
        if (accept) begin
            s1_desc_d     = bus.s_axis_pifo_info;
            s1_min_rank_d = tree_min_rank;
            s1_min_idx_d  = tree_min_idx;
            s1_any_d      = tree_any;
        end
        if (load2) begin
            m_desc_d   = s1_desc_q;
            m_bypass_d = bypass;
            m_idx_d    = s1_min_idx_q;
            // Bypassing with no calendar competition does not count towards the run.
            if (bypass && s1_any_q) begin
                run_cnt_d = (&run_cnt_q) ? run_cnt_q : run_cnt_q + 1'b1;
            end else if (!bypass) begin
                run_cnt_d = '0;
            end
            if (forced && !(&forced_cnt_q)) forced_cnt_d = forced_cnt_q + 1'b1;
        end
        if (m_valid_q && bus.m_axis_ready && m_bypass_q && !(&bypass_cnt_q)) begin
            bypass_cnt_d = bypass_cnt_q + 1'b1;
        end
    end

    always_comb begin
        pause_state_d = pause_state_q;
        pause_rank_d  = pause_rank_q;
        timer_d       = timer_q;
        case (pause_state_q)
            PAUSE_IDLE: begin
                if (bus.s_axis_gpfc_valid && bus.s_axis_gpfc_pause_quanta != '0) begin
                    pause_state_d = PAUSE_PAUSED;
                    pause_rank_d  = bus.s_axis_gpfc_pause_rank;
                    timer_d       = bus.s_axis_gpfc_pause_quanta;
                end
            end
            PAUSE_PAUSED: begin
                // A reload takes priority over the timer expiring in the same cycle.
                if (bus.s_axis_gpfc_valid && bus.s_axis_gpfc_pause_quanta != '0) begin
                    pause_rank_d = bus.s_axis_gpfc_pause_rank;
                    timer_d      = bus.s_axis_gpfc_pause_quanta;
                end else if (bus.s_axis_gpfc_valid || timer_q <= PAUSE_TIMER_WIDTH'(1)) begin
                    pause_state_d = PAUSE_IDLE;
                    timer_d       = '0;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: pause_state_d = PAUSE_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q    <= 1'b0;
            s1_desc_q     <= '0;
            s1_min_rank_q <= '0;
            s1_min_idx_q  <= '0;
            s1_any_q      <= 1'b0;
            m_valid_q     <= 1'b0;
            m_desc_q      <= '0;
            m_bypass_q    <= 1'b0;
            m_idx_q       <= '0;
            pause_state_q <= PAUSE_IDLE;
            pause_rank_q  <= '0;
            timer_q       <= '0;
            run_cnt_q     <= '0;
            bypass_cnt_q  <= '0;
            forced_cnt_q  <= '0;
        end else begin
            s1_valid_q    <= s1_valid_d;
            s1_desc_q     <= s1_desc_d;
            s1_min_rank_q <= s1_min_rank_d;
            s1_min_idx_q  <= s1_min_idx_d;
            s1_any_q      <= s1_any_d;
            m_valid_q     <= m_valid_d;
            m_desc_q      <= m_desc_d;
            m_bypass_q    <= m_bypass_d;
            m_idx_q       <= m_idx_d;
            pause_state_q <= pause_state_d;
            pause_rank_q  <= pause_rank_d;
            timer_q       <= timer_d;
            run_cnt_q     <= run_cnt_d;
            bypass_cnt_q  <= bypass_cnt_d;
            forced_cnt_q  <= forced_cnt_d;
        end
    end

    assign bus.m_axis_valid     = m_valid_q;
    assign bus.m_axis_pifo_info = m_desc_q;
    assign bus.m_axis_bypass_en = m_bypass_q;
    assign bus.m_axis_cal_idx   = m_idx_q;
    assign pause_active         = (pause_state_q == PAUSE_PAUSED);
    assign stat_bypass_cnt      = bypass_cnt_q;
    assign stat_forced_enq_cnt  = forced_cnt_q;
    assign dbg_pause_state      = pause_state_q;
    assign dbg_run_cnt          = run_cnt_q;
endmodule
